// File: rtl/instr_fetch_pkg.sv
// Shared core definitions: fetch FSM states, fetch constants, ALU ops and opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Instruction addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
// Latency: memory answers with ack at any cycle after req; req/addr hold until ack.
// Backpressure: memory stalls the fetch simply by withholding ack.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: hold on stall, redirect on branch, otherwise pc+4; flags misaligned redirects.
// Latency: purely combinational.
// Backpressure: stall forces next_pc to the current pc.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_enable,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // Stall wins over redirect; a misaligned redirect keeps the pc so the halt reports where it stopped.
  always_comb begin
    misaligned = !stall && branch_enable && !is_word_aligned(branch_target);
    next_pc    = pc + PC_INC;
    if (stall) begin
      next_pc = pc;
    end else if (branch_enable) begin
      next_pc = misaligned ? pc : branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: FETCH -> ISSUE -> FETCH loop with stall, redirect and halt handling.
// Latency: ack in cycle n gives instr_valid in cycle n+1; next request the cycle after issue completes.
// Backpressure: imem withholds ack to extend FETCH; stall holds the instruction in ISSUE.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      imem,
  input  logic               stall,
  input  logic               branch_enable,
  input  logic [31:0]        branch_target,
  input  logic               ill_instr,
  output logic [31:0]        instruction,
  output logic [31:0]        pc,
  output logic               instr_valid,
  output logic               halted,
  output logic               fetch_fault
);

  fetch_state_t state;
  logic         req_q;
  logic [31:0]  pc_nxt;
  logic         target_misaligned;

  pc_next u_pc_next (
    .pc            (pc),
    .stall         (stall),
    .branch_enable (branch_enable),
    .branch_target (branch_target),
    .next_pc       (pc_nxt),
    .misaligned    (target_misaligned)
  );

  // The request is masked by rst so memory never sees a fetch while reset is held.
  assign imem.req  = req_q && !rst;
  assign imem.addr = pc;

  // Fetch FSM with registered outputs; decode-side inputs only matter in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
      req_q       <= 1'b1;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.ack) begin
            instruction <= imem.rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ill_instr) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= S_HALT;
          end else if (stall) begin
            state <= S_ISSUE;
          end else if (target_misaligned) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            fetch_fault <= 1'b1;
            state       <= S_HALT;
          end else begin
            pc          <= pc_nxt;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state       <= S_HALT;
          instruction <= NOP_INSTR;
          instr_valid <= 1'b0;
          req_q       <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scoreboard of acked words checked at issue, plus per-scenario state checks.
// Latency: checks ack->instr_valid of one cycle and request timing around stalls and redirects.
// Backpressure: memory model inserts wait cycles before ack; stall held across issue cycles.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_enable;
  logic [31:0] branch_target;
  logic        ill_instr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;
  logic        halted;
  logic        fetch_fault;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  instr_fetch_if imem_if ();

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_if.master),
    .stall         (stall),
    .branch_enable (branch_enable),
    .branch_target (branch_target),
    .ill_instr     (ill_instr),
    .instruction   (instruction),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    branch_enable = 1'b0;
    branch_target = 32'h0;
    ill_instr     = 1'b0;
    imem_if.ack   = 1'b0;
    imem_if.rdata = $urandom;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Starts just after an edge in FETCH; ends at the falling edge of the first ISSUE cycle.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int waits, input string tag);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        imem_if.ack   = 1'b1;
        imem_if.rdata = word;
      end
      @(negedge clk);
      n_tests++;
      if (imem_if.req !== 1'b1 || imem_if.addr !== exp_addr || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s fetch cyc%0d: req=%b addr=%h valid=%b, want req=1 addr=%h valid=0",
                 tag, i, imem_if.req, imem_if.addr, instr_valid, exp_addr);
      end
      if (i == waits) sb.push_back('{pc: exp_addr, instr: word});
      cyc();
    end
    imem_if.ack   = 1'b0;
    imem_if.rdata = $urandom;
    @(negedge clk);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s issue: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (instr_valid !== 1'b1 || pc !== e.pc || instruction !== e.instr || imem_if.req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s issue: valid=%b pc=%h instr=%h req=%b, want valid=1 pc=%h instr=%h req=0",
                 tag, instr_valid, pc, instruction, imem_if.req, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    imem_if.ack = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_fault !== 1'b0 ||
        instruction !== NOP || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: req=%b valid=%b halted=%b fault=%b instr=%h pc=%h, want 0 0 0 0 %h 0",
               imem_if.req, instr_valid, halted, fetch_fault, instruction, pc, NOP);
    end
    cyc();
    rst = 1'b0;
    imem_if.ack = 1'b0;
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h0, 32'h0000_0013, 2, "first");
    cyc();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h4 || instr_valid !== 1'b0 || instruction !== NOP) begin
      n_fail++;
      $display("FAIL first_next: req=%b addr=%h valid=%b instr=%h, want 1 00000004 0 %h",
               imem_if.req, imem_if.addr, instr_valid, instruction, NOP);
    end
    cyc();
  endtask

  task automatic test_stall();
    do_fetch(32'h4, 32'h00A0_0093, 0, "stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || pc !== 32'h4 || instruction !== 32'h00A0_0093 || imem_if.req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h req=%b, want 1 00000004 00a00093 0",
                 i, instr_valid, pc, instruction, imem_if.req);
      end
    end
    stall = 1'b0;
    cyc();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h8 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, want 1 00000008 0",
               imem_if.req, imem_if.addr, instr_valid);
    end
    cyc();
  endtask

  task automatic test_branch();
    do_fetch(32'h8, 32'h0000_0063, 1, "branch");
    branch_enable = 1'b1;
    branch_target = 32'h0000_0100;
    cyc();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h100 || pc !== 32'h100 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch: req=%b addr=%h pc=%h valid=%b, want 1 00000100 00000100 0",
               imem_if.req, imem_if.addr, pc, instr_valid);
    end
    cyc();
  endtask

  task automatic test_branch_stalled();
    do_fetch(32'h100, 32'h1234_5678, 2, "br_stall");
    stall         = 1'b1;
    branch_enable = 1'b1;
    branch_target = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || pc !== 32'h100 || imem_if.req !== 1'b0) begin
        n_fail++;
        $display("FAIL br_stall_hold%0d: valid=%b pc=%h req=%b, want 1 00000100 0",
                 i, instr_valid, pc, imem_if.req);
      end
    end
    stall = 1'b0;
    cyc();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h200) begin
      n_fail++;
      $display("FAIL br_stall_redirect: req=%b addr=%h, want 1 00000200", imem_if.req, imem_if.addr);
    end
    cyc();
  endtask

  task automatic test_wrap();
    do_fetch(32'h200, 32'h0040_006F, 0, "wrap_pre");
    branch_enable = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    cyc();
    clear_inputs();
    do_fetch(32'hFFFF_FFFC, 32'h0010_0113, 1, "wrap");
    cyc();
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: req=%b addr=%h pc=%h, want 1 00000000 00000000", imem_if.req, imem_if.addr, pc);
    end
    cyc();
  endtask

  task automatic test_fetch_ignores();
    stall         = 1'b1;
    branch_enable = 1'b1;
    branch_target = 32'h0000_0302;
    ill_instr     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0 || halted !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_ignore%0d: req=%b addr=%h halted=%b valid=%b, want 1 00000000 0 0",
                 i, imem_if.req, imem_if.addr, halted, instr_valid);
      end
      cyc();
    end
    clear_inputs();
    do_fetch(32'h0, 32'h0020_0193, 0, "after_ignore");
    cyc();
  endtask

  task automatic test_misaligned();
    do_fetch(32'h4, 32'h0000_0463, 0, "misal");
    branch_enable = 1'b1;
    branch_target = 32'h0000_0102;
    cyc();
    for (int i = 0; i < 4; i++) begin
      imem_if.ack   = 1'b1;
      imem_if.rdata = $urandom;
      stall         = 1'($urandom_range(0, 1));
      branch_target = 32'h0000_0100;
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1 || fetch_fault !== 1'b1 || imem_if.req !== 1'b0 || instr_valid !== 1'b0 ||
          instruction !== NOP || pc !== 32'h4) begin
        n_fail++;
        $display("FAIL misaligned%0d: halted=%b fault=%b req=%b valid=%b instr=%h pc=%h, want 1 1 0 0 %h 00000004",
                 i, halted, fetch_fault, imem_if.req, instr_valid, instruction, pc, NOP);
      end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_illegal();
    apply_reset();
    do_fetch(32'h0, 32'hFFFF_FFFF, 0, "illegal");
    ill_instr     = 1'b1;
    stall         = 1'b1;
    branch_enable = 1'b1;
    branch_target = 32'h0000_0100;
    cyc();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1 || fetch_fault !== 1'b0 || imem_if.req !== 1'b0 || instr_valid !== 1'b0 ||
          pc !== 32'h0 || instruction !== NOP) begin
        n_fail++;
        $display("FAIL illegal%0d: halted=%b fault=%b req=%b valid=%b pc=%h instr=%h, want 1 0 0 0 0 %h",
                 i, halted, fetch_fault, imem_if.req, instr_valid, pc, instruction, NOP);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    do_fetch(32'h0, 32'h0030_0213, 0, "mid_pre");
    cyc();
    rst           = 1'b1;
    imem_if.ack   = 1'b1;
    imem_if.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++;
    if (imem_if.req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_req: req=%b, want 0", imem_if.req);
    end
    cyc();
    rst         = 1'b0;
    imem_if.ack = 1'b0;
    n_tests++;
    if (pc !== 32'h0 || instruction !== NOP || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_state: pc=%h instr=%h valid=%b halted=%b fault=%b, want 0 %h 0 0 0",
               pc, instruction, instr_valid, halted, fetch_fault, NOP);
    end
    do_fetch(32'h0, 32'h0000_0055, 1, "mid_post");
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch();
    test_branch_stalled();
    test_wrap();
    test_fetch_ignores();
    test_misaligned();
    test_illegal();
    test_reset_mid_fetch();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction output value whenever no fetched word is held.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-006 imem_addr  output  32  SHALL be the fetch byte address.
REQ-007 imem_ack  input  1  SHALL mean imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  SHALL be the fetched word.
REQ-009 stall  input  1  SHALL hold the current instruction in issue.
REQ-010 branch_enable  input  1  SHALL be the taken-branch/redirect request from the decode/execute side.
REQ-011 branch_target  input  32  SHALL be the redirect byte address.
REQ-012 ill_instr  input  1  SHALL be the illegal-instruction flag from the control decoder.
REQ-013 instruction  output  32  SHALL be the word presented to the control decoder.
REQ-014 pc  output  32  SHALL be the address of the presented instruction.
REQ-015 instr_valid  output  1  SHALL mean instruction/pc are valid for decode this cycle.
REQ-016 halted  output  1  SHALL mean the fetch stage has stopped.
REQ-017 fetch_fault  output  1  SHALL mean the halt was caused by a misaligned redirect target.

Function
REQ-018 The FSM SHALL have states FETCH, ISSUE, HALT.
REQ-019 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; on imem_ack the FSM SHALL latch imem_rdata into instruction and go to ISSUE (ack in cycle n -> instr_valid=1 in n+1).
REQ-020 FETCH without imem_ack SHALL hold imem_req and imem_addr stable indefinitely.
REQ-021 ISSUE: imem_req=0, instr_valid=1; ill_instr, stall, branch_enable SHALL be sampled only in ISSUE, in priority ill_instr > stall > branch_enable.
REQ-022 ISSUE with ill_instr=1 SHALL go to HALT regardless of stall/branch_enable.
REQ-023 ISSUE with stall=1 (no ill_instr) SHALL stay in ISSUE with pc and instruction unchanged.
REQ-024 ISSUE with branch_enable=1, branch_target[1:0]==0 SHALL load pc<=branch_target and go to FETCH.
REQ-025 ISSUE with branch_enable=1, branch_target[1:0]!=0 SHALL go to HALT with fetch_fault=1, pc unchanged.
REQ-026 ISSUE otherwise SHALL load pc<=pc+4 (modulo 2^32: 32'hFFFF_FFFC wraps to 0) and go to FETCH.
REQ-027 On leaving ISSUE, instruction SHALL be set to NOP_INSTR.
REQ-028 HALT: imem_req=0, instr_valid=0, halted=1, instruction=NOP_INSTR; only rst SHALL exit HALT.
REQ-029 branch_enable, stall, ill_instr in FETCH or HALT SHALL be ignored.

Reset
REQ-030 rst=1 SHALL, at the next edge and regardless of state (including mid-fetch with ack pending), set state=FETCH, pc=RESET_PC, instruction=NOP_INSTR, instr_valid=0, halted=0, fetch_fault=0.
REQ-031 While rst=1, imem_req SHALL be 0; an imem_ack arriving in the reset cycle SHALL be discarded.

Structure
REQ-032 State encoding, RESET_PC default, NOP_INSTR and the PC increment constant 4 SHALL live in the shared package alongside the ALU and opcode definitions.
REQ-033 Next-PC selection (pc+4 / branch_target / hold, plus alignment check) SHALL be one sub-module, pc_next.

Verification
REQ-034 Reset, imem acks 32'h0000_0013 after 2 wait cycles -> imem_addr=0 held 3 cycles, instr_valid=1 one cycle after ack with pc=0, next fetch at 4.
REQ-035 stall=1 for 3 ISSUE cycles then 0 -> instruction/pc stable 4 cycles, then fetch at pc+4.
REQ-036 branch_enable=1, branch_target=32'h0000_0100 in ISSUE -> next imem_addr=0x100; same with stall=1 -> no redirect until stall drops.
REQ-037 branch_target=32'h0000_0102 -> halted=1, fetch_fault=1, imem_req=0 thereafter; ill_instr=1 with branch_enable=1 -> halted=1, fetch_fault=0.
REQ-038 pc=32'hFFFF_FFFC sequential issue -> next imem_addr=0; rst asserted during FETCH with ack -> pc=RESET_PC, word discarded.
